i2c_slave_write: RTL and testbench

I2C_SLAVE_WRITE -- requirements
Module: i2c_slave_write

---
 rtl/i2c_slave_write_if.sv | 17 +
 rtl/i2c_slave_write.sv | 169 ++++++++++++++++
 tb/tb_i2c_slave_write.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_write_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2c_slave_write_if : SCL input and register-write strobe bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
// SDA is an open-drain pad and stays a plain inout net on the target.
interface i2c_slave_write_if;
  logic       scl;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  modport slave  (input scl, output wr_valid, wr_addr, wr_data, busy);
  modport master (output scl, input wr_valid, wr_addr, wr_data, busy);
endinterface
`default_nettype wire

// File: rtl/i2c_slave_write.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2c_slave_write : write-only I2C target, emits (pointer, data) strobes.
// Build option: I2C_SLAVE_AUTOINC_EN enables multi-byte auto-increment writes.
// Revision: 1.0
// ---------------------------------------------------------------------------
module i2c_slave_write #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  wire logic        clk,
  input  wire logic        reset,
  inout  wire              sda,
  i2c_slave_write_if.slave bus
);

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_ADDR     = 3'd1;
  localparam logic [2:0] c_ST_ACK_ADDR = 3'd2;
  localparam logic [2:0] c_ST_REG      = 3'd3;
  localparam logic [2:0] c_ST_ACK_REG  = 3'd4;
  localparam logic [2:0] c_ST_DATA     = 3'd5;
  localparam logic [2:0] c_ST_ACK_DATA = 3'd6;
  localparam logic [2:0] c_ST_IGNORE   = 3'd7;

  logic       r_scl_m, r_ssc, r_ssc_q;
  logic       r_sda_m, r_ssd, r_ssd_q;
  logic [2:0] r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [6:0] r_shift, w_shift_nxt;
  logic [7:0] r_ptr, w_ptr_nxt;
  logic       r_ack_drv, w_ack_drv_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_wr_valid, w_wr_valid_nxt;
  logic [7:0] r_wr_addr, w_wr_addr_nxt;
  logic [7:0] r_wr_data, w_wr_data_nxt;
  logic       w_sda_oe;

  // Requiring SCL high on both samples keeps coincident SCL/SDA edges from
  // being mistaken for START/STOP.
  wire       w_scl_rise = r_ssc & ~r_ssc_q;
  wire       w_scl_fall = ~r_ssc & r_ssc_q;
  wire       w_start    = r_ssc & r_ssc_q & r_ssd_q & ~r_ssd;
  wire       w_stop     = r_ssc & r_ssc_q & ~r_ssd_q & r_ssd;
  wire [7:0] w_byte     = {r_shift, r_ssd};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_m    <= 1'b1;
      r_ssc      <= 1'b1;
      r_ssc_q    <= 1'b1;
      r_sda_m    <= 1'b1;
      r_ssd      <= 1'b1;
      r_ssd_q    <= 1'b1;
      r_state    <= c_ST_IDLE;
      r_cnt      <= 3'd0;
      r_shift    <= 7'd0;
      r_ptr      <= 8'd0;
      r_ack_drv  <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= 8'd0;
      r_wr_data  <= 8'd0;
    end else begin
      r_scl_m    <= bus.scl;
      r_ssc      <= r_scl_m;
      r_ssc_q    <= r_ssc;
      r_sda_m    <= sda;
      r_ssd      <= r_sda_m;
      r_ssd_q    <= r_ssd;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_ptr      <= w_ptr_nxt;
      r_ack_drv  <= w_ack_drv_nxt;
      r_busy     <= w_busy_nxt;
      r_wr_valid <= w_wr_valid_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_ptr_nxt      = r_ptr;
    w_ack_drv_nxt  = r_ack_drv;
    w_busy_nxt     = r_busy;
    w_wr_valid_nxt = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    if (w_start) begin
      w_state_nxt   = c_ST_ADDR;
      w_cnt_nxt     = 3'd0;
      w_ack_drv_nxt = 1'b0;
    end else if (w_stop) begin
      w_state_nxt   = c_ST_IDLE;
      w_cnt_nxt     = 3'd0;
      w_ack_drv_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
    end else begin
      case (r_state)
        c_ST_ADDR, c_ST_REG, c_ST_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte[6:0];
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              if (r_state == c_ST_ADDR) begin
                if (w_byte[7:1] == SLAVE_ADDR && !w_byte[0]) begin
                  w_state_nxt = c_ST_ACK_ADDR;
                  w_busy_nxt  = 1'b1;
                end else begin
                  w_state_nxt = c_ST_IGNORE;
                end
              end else if (r_state == c_ST_REG) begin
                w_ptr_nxt   = w_byte;
                w_state_nxt = c_ST_ACK_REG;
              end else begin
                w_wr_valid_nxt = 1'b1;
                w_wr_addr_nxt  = r_ptr;
                w_wr_data_nxt  = w_byte;
                w_state_nxt    = c_ST_ACK_DATA;
              end
            end
          end
        end
        c_ST_ACK_ADDR, c_ST_ACK_REG, c_ST_ACK_DATA: begin
          // First SCL fall starts the ACK drive, the second one ends it.
          if (w_scl_fall) begin
            if (!r_ack_drv) begin
              w_ack_drv_nxt = 1'b1;
            end else begin
              w_ack_drv_nxt = 1'b0;
              if (r_state == c_ST_ACK_ADDR) begin
                w_state_nxt = c_ST_REG;
              end else if (r_state == c_ST_ACK_REG) begin
                w_state_nxt = c_ST_DATA;
              end else begin
`ifdef I2C_SLAVE_AUTOINC_EN
                w_ptr_nxt   = r_ptr + 8'd1;
                w_state_nxt = c_ST_DATA;
`else
                w_state_nxt = c_ST_IGNORE;
`endif
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_sda_oe = 1'b0;
    case (r_state)
      c_ST_ACK_ADDR, c_ST_ACK_REG, c_ST_ACK_DATA: w_sda_oe = r_ack_drv;
      default:                                    w_sda_oe = 1'b0;
    endcase
  end

  assign sda          = w_sda_oe ? 1'b0 : 1'bz;
  assign bus.wr_valid = r_wr_valid;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_write.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_i2c_slave_write : bit-banged I2C master against a byte-level write model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_i2c_slave_write;
`ifdef I2C_SLAVE_AUTOINC_EN
  localparam bit c_AUTOINC = 1'b1;
`else
  localparam bit c_AUTOINC = 1'b0;
`endif
  localparam int c_Q = 6;

  logic clk = 1'b0;
  logic reset;
  logic m_oe;
  wire  sda;
  i2c_slave_write_if bus ();

  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_write #(.SLAVE_ADDR(7'h50)) dut (
    .clk   (clk),
    .reset (reset),
    .sda   (sda),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  tx_q[$];
  logic [15:0] obs_q[$];
  logic [15:0] exp_wr_q[$];
  bit          exp_ack_q[$];

  always @(negedge clk) if (bus.wr_valid) obs_q.push_back({bus.wr_addr, bus.wr_data});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic q();
    repeat (c_Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_oe = 1'b0; q(); bus.scl = 1'b1; q(); m_oe = 1'b1; q(); bus.scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_oe = 1'b1; q(); bus.scl = 1'b1; q(); m_oe = 1'b0; q(); q();
  endtask

  task automatic send_bit(input logic b);
    m_oe = ~b; q(); bus.scl = 1'b1; q(); q(); bus.scl = 1'b0; q();
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_oe = 1'b0; q(); bus.scl = 1'b1; q();
    ack = (sda === 1'b0);
    q(); bus.scl = 1'b0; q();
  endtask

  // Byte-level view: a matched write ACKs address, register and first data
  // byte; later data bytes only with auto-increment, to pointer+offset.
  task automatic model();
    bit match;
    bit a;
    exp_ack_q.delete();
    exp_wr_q.delete();
    match = (tx_q[0] == {7'h50, 1'b0});
    for (int i = 0; i < tx_q.size(); i++) begin
      a = match && (i <= 2 || c_AUTOINC);
      exp_ack_q.push_back(a);
      if (a && i >= 2) exp_wr_q.push_back({tx_q[1] + 8'(i - 2), tx_q[i]});
    end
  endtask

  task automatic run_txn(input string name);
    bit ack;
    model();
    obs_q.delete();
    i2c_start();
    for (int i = 0; i < tx_q.size(); i++) begin
      send_byte(tx_q[i], ack);
      check($sformatf("%s_ack%0d", name, i), 32'(ack), 32'(exp_ack_q[i]));
      if (i == 0) check({name, "_busy"}, 32'(bus.busy), 32'(exp_ack_q[0]));
    end
    i2c_stop();
    check({name, "_busy_end"}, 32'(bus.busy), 32'd0);
    check({name, "_nwr"}, 32'(obs_q.size()), 32'(exp_wr_q.size()));
    for (int i = 0; i < exp_wr_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_wr%0d", name, i), 32'(obs_q[i]), 32'(exp_wr_q[i]));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ack;
    int n;
    reset = 1'b1; m_oe = 1'b0; bus.scl = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sda", 32'(sda), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.wr_valid), 32'd0);
    check("rst_wr", 32'({bus.wr_addr, bus.wr_data}), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    tx_q = '{8'hA0, 8'h12, 8'hA5};         run_txn("basic");
    tx_q = '{8'hA2, 8'h12, 8'hA5};         run_txn("other_addr");
    tx_q = '{8'hA1, 8'h12, 8'hA5};         run_txn("read_req");
    tx_q = '{8'hA0, 8'hFF, 8'h11, 8'h22};  run_txn("wrap");

    for (int t = 0; t < 12; t++) begin
      tx_q.delete();
      case ($urandom_range(0, 4))
        0, 1:    tx_q.push_back(8'hA0);
        2:       tx_q.push_back(8'hA2);
        3:       tx_q.push_back(8'hA1);
        default: tx_q.push_back(8'($urandom));
      endcase
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      run_txn($sformatf("rand%0d", t));
    end

    // STOP in the middle of a data byte
    obs_q.delete();
    i2c_start();
    send_byte(8'hA0, ack); check("part_ack_a", 32'(ack), 32'd1);
    send_byte(8'h33, ack); check("part_ack_r", 32'(ack), 32'd1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    check("part_nwr", 32'(obs_q.size()), 32'd0);
    check("part_busy", 32'(bus.busy), 32'd0);

    // repeated START in the middle of the register byte
    i2c_start();
    send_byte(8'hA0, ack); check("rs_ack_a", 32'(ack), 32'd1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check("rs_nwr", 32'(obs_q.size()), 32'd0);
    tx_q = '{8'hA0, 8'h34, 8'h5A};         run_txn("rs_txn");

    // reset while the address ACK is being driven
    obs_q.delete();
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'hA0 >> i));
    m_oe = 1'b0; q(); bus.scl = 1'b1; q();
    check("rack_low", 32'(sda), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rack_release", 32'(sda), 32'd1);
    check("rack_busy", 32'(bus.busy), 32'd0);
    q(); bus.scl = 1'b0; q();
    i2c_stop();
    check("rack_nwr", 32'(obs_q.size()), 32'd0);
    tx_q = '{8'hA0, 8'h56, 8'h78};         run_txn("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
